// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - Avalon-style memory port shared by fetch and data access
interface fetch_sequencer_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output mem_address, mem_read, mem_write,
    input  waitrequest, readdata
  );

  modport slave (
    input  mem_address, mem_read, mem_write,
    output waitrequest, readdata
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multicycle instruction sequencer and memory port arbiter (optional FETCH_SEQ_BYTESWAP_EN)
module fetch_sequencer #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              pc_address,
  input  logic                     pc_halt,
  input  logic [31:0]              data_address,
  input  logic                     data_read,
  input  logic                     data_write,
  fetch_sequencer_if.master        mem,
  output logic [31:0]              instr,
  output logic                     fetch,
  output logic                     exec1,
  output logic                     exec2,
  output logic                     stall,
  output logic                     active
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC1  = 2'd1,
    ST_EXEC2  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        active_q, active_d;
  logic [31:0] fetch_word;
  logic        fetch_rd;
  logic        data_rd;
  logic        data_wr;

`ifdef FETCH_SEQ_BYTESWAP_EN
  // Little-endian bus: reverse byte order before the word reaches the IR.
  assign fetch_word = {mem.readdata[7:0], mem.readdata[15:8],
                       mem.readdata[23:16], mem.readdata[31:24]};
`else
  assign fetch_word = mem.readdata;
`endif

  assign instr  = instr_q;
  assign active = active_q;

  // Memory port arbitration and state strobes; everything is quiet while reset is high.
  always_comb begin
    fetch_rd = 1'b0;
    data_rd  = 1'b0;
    data_wr  = 1'b0;
    if (!reset) begin
      fetch_rd = (state_q == ST_FETCH) && !pc_halt;
      data_rd  = (state_q == ST_EXEC2) && data_read;
      // A load wins when the ALU flags both directions.
      data_wr  = (state_q == ST_EXEC2) && data_write && !data_read;
    end

    mem.mem_read  = fetch_rd || data_rd;
    mem.mem_write = data_wr;
    if (fetch_rd) begin
      mem.mem_address = pc_address;
    end else if (data_rd || data_wr) begin
      mem.mem_address = data_address;
    end else begin
      mem.mem_address = 32'h0000_0000;
    end

    stall = (fetch_rd || data_rd || data_wr) && mem.waitrequest;
    fetch = fetch_rd && !mem.waitrequest;
    exec1 = !reset && (state_q == ST_EXEC1);
    exec2 = !reset && (state_q == ST_EXEC2);
  end

  // Next-state, instruction-register and active-flag computation.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    active_d = active_q;
    if (reset) begin
      state_d  = ST_FETCH;
      instr_d  = RESET_INSTR;
      active_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (pc_halt) begin
            state_d  = ST_HALTED;
            active_d = 1'b0;
          end else if (!mem.waitrequest) begin
            state_d = ST_EXEC1;
            instr_d = fetch_word;
          end
        end
        ST_EXEC1: state_d = ST_EXEC2;
        ST_EXEC2: begin
          if (!((data_rd || data_wr) && mem.waitrequest)) begin
            state_d = ST_FETCH;
          end
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_FETCH;
      endcase
    end
  end

  // The only state: sequencer phase, instruction register and active flag.
  always_ff @(posedge clk) begin
    state_q  <= state_d;
    instr_q  <= instr_d;
    active_q <= active_d;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
  localparam logic [31:0] TB_RESET_INSTR = 32'hA5A5_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_address;
  logic        pc_halt;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] instr;
  logic        fetch, exec1, exec2, stall, active;
  int          total = 0;
  int          bad = 0;

  fetch_sequencer_if bus();

  fetch_sequencer #(.RESET_INSTR(TB_RESET_INSTR)) dut (
    .clk(clk), .reset(reset), .pc_address(pc_address), .pc_halt(pc_halt),
    .data_address(data_address), .data_read(data_read), .data_write(data_write),
    .mem(bus.master), .instr(instr), .fetch(fetch), .exec1(exec1), .exec2(exec2),
    .stall(stall), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [5:0]  flags;
    logic [31:0] ins;
  } rec_t;

  rec_t plan[$];

  function automatic logic [31:0] xform(input logic [31:0] w);
    logic [31:0] r;
    r = w;
`ifdef FETCH_SEQ_BYTESWAP_EN
    for (int b = 0; b < 4; b++) r[8*b +: 8] = w[8*(3-b) +: 8];
`endif
    return r;
  endfunction

  function automatic logic [5:0] obs_flags();
    return {bus.mem_read, bus.mem_write, fetch, exec1, exec2, stall};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    tick();
    reset = 1'b1; pc_halt = 1'b0; data_read = 1'b0; data_write = 1'b0;
    bus.waitrequest = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic push(input logic wr, input logic [31:0] a, input logic [5:0] f, input logic [31:0] ins);
    rec_t r;
    r.wr = wr; r.addr = a; r.flags = f; r.ins = ins;
    plan.push_back(r);
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b1; pc_halt = 1'b0; data_read = 1'b1; data_write = 1'b1;
    bus.waitrequest = 1'b1; pc_address = 32'h1234_5678; data_address = 32'h55;
    #1;
    total++;
    if (obs_flags() !== 6'b0 || bus.mem_address !== 32'h0) begin
      bad++; $display("FAIL reset_outputs flags=%b addr=%h required flags=000000 addr=0", obs_flags(), bus.mem_address);
    end
    tick();
    #1;
    total++;
    if (instr !== TB_RESET_INSTR || active !== 1'b1) begin
      bad++; $display("FAIL reset_regs instr=%h active=%b required instr=%h active=1", instr, active, TB_RESET_INSTR);
    end
    @(posedge clk);
    #1 reset = 1'b0; data_read = 1'b0; data_write = 1'b0; bus.waitrequest = 1'b0;
    tick(); #1;
    total++;
    if (stall !== 1'b0 || exec1 !== 1'b0 || exec2 !== 1'b0 || active !== 1'b1) begin
      bad++; $display("FAIL reset_state stall=%b exec1=%b exec2=%b active=%b required 0 0 0 1", stall, exec1, exec2, active);
    end
  endtask

  task automatic test_basic_fetch();
    apply_reset();
    tick(); pc_address = 32'hBFC0_0000; bus.readdata = 32'h2402_0005; #1;
    total++;
    if (bus.mem_read !== 1'b1 || bus.mem_address !== 32'hBFC0_0000 || fetch !== 1'b1) begin
      bad++; $display("FAIL basic_fetch rd=%b addr=%h fetch=%b required 1 bfc00000 1", bus.mem_read, bus.mem_address, fetch);
    end
    tick(); #1;
    total++;
    if (instr !== xform(32'h2402_0005) || exec1 !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_address !== 32'h0) begin
      bad++; $display("FAIL basic_exec1 instr=%h exec1=%b rd=%b addr=%h required instr=%h exec1=1 rd=0 addr=0", instr, exec1, bus.mem_read, bus.mem_address, xform(32'h2402_0005));
    end
    tick(); #1;
    total++;
    if (exec2 !== 1'b1 || exec1 !== 1'b0 || fetch !== 1'b0) begin
      bad++; $display("FAIL basic_exec2 exec2=%b exec1=%b fetch=%b required 1 0 0", exec2, exec1, fetch);
    end
    tick(); #1;
    total++;
    if (fetch !== 1'b1 || exec2 !== 1'b0 || bus.mem_address !== 32'hBFC0_0000) begin
      bad++; $display("FAIL basic_refetch fetch=%b exec2=%b addr=%h required 1 0 bfc00000", fetch, exec2, bus.mem_address);
    end
  endtask

  task automatic test_fetch_stall();
    apply_reset();
    pc_address = 32'h0040_0100; bus.readdata = 32'h0000_0021;
    for (int c = 0; c < 3; c++) begin
      tick(); bus.waitrequest = 1'b1; #1;
      total++;
      if (stall !== 1'b1 || fetch !== 1'b0 || bus.mem_read !== 1'b1 || bus.mem_address !== 32'h0040_0100) begin
        bad++; $display("FAIL fetch_stall c=%0d stall=%b fetch=%b rd=%b addr=%h required 1 0 1 00400100", c, stall, fetch, bus.mem_read, bus.mem_address);
      end
    end
    tick(); bus.waitrequest = 1'b0; #1;
    total++;
    if (fetch !== 1'b1 || stall !== 1'b0) begin
      bad++; $display("FAIL fetch_release fetch=%b stall=%b required 1 0", fetch, stall);
    end
    tick(); #1;
    tick(); #1;
    total++;
    if (exec2 !== 1'b1) begin
      bad++; $display("FAIL fetch_stall_exec2 exec2=%b required 1", exec2);
    end
    tick(); #1;
    total++;
    if (bus.mem_read !== 1'b1 || exec2 !== 1'b0 || instr !== xform(32'h0000_0021)) begin
      bad++; $display("FAIL fetch_stall_len rd=%b exec2=%b instr=%h required 1 0 %h", bus.mem_read, exec2, instr, xform(32'h0000_0021));
    end
  endtask

  task automatic test_data_read();
    apply_reset();
    pc_address = 32'h0040_0200; bus.readdata = 32'h8C42_0000;
    tick(); #1;
    tick(); #1;
    for (int c = 0; c < 3; c++) begin
      tick(); data_read = 1'b1; data_address = 32'h0000_1000; bus.waitrequest = (c < 2); #1;
      total++;
      if (bus.mem_address !== 32'h0000_1000 || bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 ||
          exec2 !== 1'b1 || stall !== (c < 2)) begin
        bad++; $display("FAIL data_read c=%0d addr=%h rd=%b wr=%b exec2=%b stall=%b required 00001000 1 0 1 %b", c, bus.mem_address, bus.mem_read, bus.mem_write, exec2, stall, c < 2);
      end
    end
    tick(); bus.waitrequest = 1'b0; #1;
    total++;
    if (exec2 !== 1'b0 || bus.mem_address !== 32'h0040_0200 || fetch !== 1'b1) begin
      bad++; $display("FAIL data_read_done exec2=%b addr=%h fetch=%b required 0 00400200 1", exec2, bus.mem_address, fetch);
    end
    data_read = 1'b0;
  endtask

  task automatic test_halt();
    apply_reset();
    tick(); pc_halt = 1'b1; bus.waitrequest = 1'b1; pc_address = 32'h0; #1;
    total++;
    if (bus.mem_read !== 1'b0 || stall !== 1'b0 || fetch !== 1'b0) begin
      bad++; $display("FAIL halt_entry rd=%b stall=%b fetch=%b required 0 0 0", bus.mem_read, stall, fetch);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      pc_halt = 1'($urandom); bus.waitrequest = 1'($urandom);
      data_read = 1'($urandom); data_write = 1'($urandom); data_address = $urandom;
      #1;
      total++;
      if (obs_flags() !== 6'b0 || bus.mem_address !== 32'h0 || active !== 1'b0) begin
        bad++; $display("FAIL halted c=%0d flags=%b addr=%h active=%b required 000000 0 0", c, obs_flags(), bus.mem_address, active);
      end
    end
    apply_reset();
    tick(); pc_address = 32'h0000_0400; #1;
    total++;
    if (active !== 1'b1 || bus.mem_read !== 1'b1 || bus.mem_address !== 32'h0000_0400) begin
      bad++; $display("FAIL halt_recover active=%b rd=%b addr=%h required 1 1 00000400", active, bus.mem_read, bus.mem_address);
    end
  endtask

  task automatic test_reset_mid_store();
    apply_reset();
    pc_address = 32'h0040_0300;
    tick(); #1;
    tick(); #1;
    tick(); data_write = 1'b1; data_address = 32'h0000_2000; bus.waitrequest = 1'b1; #1;
    total++;
    if (bus.mem_write !== 1'b1 || stall !== 1'b1 || bus.mem_address !== 32'h0000_2000) begin
      bad++; $display("FAIL store_stall wr=%b stall=%b addr=%h required 1 1 00002000", bus.mem_write, stall, bus.mem_address);
    end
    tick(); reset = 1'b1; #1;
    total++;
    if (obs_flags() !== 6'b0 || bus.mem_address !== 32'h0) begin
      bad++; $display("FAIL store_reset flags=%b addr=%h required 000000 0", obs_flags(), bus.mem_address);
    end
    tick(); reset = 1'b0; #1;
    total++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || exec2 !== 1'b0 || bus.mem_address !== 32'h0040_0300) begin
      bad++; $display("FAIL store_after_reset rd=%b wr=%b exec2=%b addr=%h required 1 0 0 00400300", bus.mem_read, bus.mem_write, exec2, bus.mem_address);
    end
    data_write = 1'b0; bus.waitrequest = 1'b0;
  endtask

  task automatic test_byteswap();
    logic [31:0] want;
`ifdef FETCH_SEQ_BYTESWAP_EN
    want = 32'h2402_0005;
`else
    want = 32'h0500_0224;
`endif
    apply_reset();
    tick(); pc_address = 32'h0000_0800; bus.readdata = 32'h0500_0224; #1;
    tick(); #1;
    total++;
    if (instr !== want) begin
      bad++; $display("FAIL byteswap instr=%h required %h", instr, want);
    end
  endtask

  task automatic test_random();
    logic [31:0] cur, pc, da, rd;
    logic [5:0]  mf;
    int          fw, dw, kind;
    logic        rdq, wrq;
    apply_reset();
    cur = TB_RESET_INSTR;
    for (int k = 0; k < 30; k++) begin
      fw = int'($urandom_range(0, 3)); dw = int'($urandom_range(0, 3)); kind = int'($urandom_range(0, 3));
      pc = $urandom | 32'h4; da = $urandom; rd = $urandom;
      rdq = (kind == 1 || kind == 3);
      wrq = (kind == 2 || kind == 3);
      plan.delete();
      for (int i = 0; i < fw; i++) push(1'b1, pc, 6'b100001, cur);
      push(1'b0, pc, 6'b101000, cur);
      cur = xform(rd);
      push(1'($urandom), 32'h0, 6'b000100, cur);
      if (!rdq && !wrq) begin
        push(1'($urandom), 32'h0, 6'b000010, cur);
      end else begin
        mf = rdq ? 6'b100010 : 6'b010010;
        for (int i = 0; i < dw; i++) push(1'b1, da, mf | 6'b000001, cur);
        push(1'b0, da, mf, cur);
      end
      foreach (plan[i]) begin
        tick();
        pc_address = pc; data_address = da; data_read = rdq; data_write = wrq;
        bus.readdata = rd; bus.waitrequest = plan[i].wr;
        #1;
        total++;
        if (obs_flags() !== plan[i].flags || bus.mem_address !== plan[i].addr ||
            instr !== plan[i].ins || active !== 1'b1) begin
          bad++;
          $display("FAIL random k=%0d i=%0d flags=%b addr=%h instr=%h active=%b required flags=%b addr=%h instr=%h active=1",
                   k, i, obs_flags(), bus.mem_address, instr, active, plan[i].flags, plan[i].addr, plan[i].ins);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; pc_address = 32'h0; pc_halt = 1'b0; data_address = 32'h0;
    data_read = 1'b0; data_write = 1'b0; bus.waitrequest = 1'b0; bus.readdata = 32'h0;
    test_reset();
    test_basic_fetch();
    test_fetch_stall();
    test_data_read();
    test_halt();
    test_reset_mid_store();
    test_byteswap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached without finishing");
    $fatal(1);
  end
endmodule
